// File: rtl/vram_arbiter_pkg.sv
// +-----------------------------------------------------------------------------+
// | vram_arbiter_pkg : shared VRAM width and arbiter state encodings            |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package vram_arbiter_pkg;

   localparam int VRAM_ADDR_WIDTH = 15;

   // State value names the operation presented on the mem_* port this cycle
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/vram_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | vram_arbiter_if : CPU write, GPU fetch and VRAM port bundle                 |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface vram_arbiter_if #(
   parameter int ADDR_W = vram_arbiter_pkg::VRAM_ADDR_WIDTH
);
   logic              cs;
   logic [ADDR_W-1:0] address;
   logic [7:0]        data;
   logic              cpu_full;
   logic              overflow;
   logic              visible;
   logic              gpu_req;
   logic [ADDR_W-1:0] gpu_addr;
   logic              gpu_gnt;
   logic [7:0]        gpu_rdata;
   logic              gpu_rvalid;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [7:0]        mem_rdata;

   modport slave (
      input  cs, address, data, visible, gpu_req, gpu_addr, mem_rdata,
      output cpu_full, overflow, gpu_gnt, gpu_rdata, gpu_rvalid,
             mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output cs, address, data, visible, gpu_req, gpu_addr, mem_rdata,
      input  cpu_full, overflow, gpu_gnt, gpu_rdata, gpu_rvalid,
             mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

`default_nettype wire

// File: rtl/vram_write_fifo.sv
// +-----------------------------------------------------------------------------+
// | vram_write_fifo : CPU write buffer, head visible combinationally            |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module vram_write_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   input  wire logic                   push,
   input  wire logic                   pop,
   input  wire logic [WIDTH-1:0]       din,
   output logic      [WIDTH-1:0]       dout,
   output logic                        full,
   output logic                        empty,
   output logic      [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign empty = (r_count == '0);
   assign full  = (r_count == (PTR_W+1)'(DEPTH));
   assign count = r_count;
   assign dout  = r_mem[r_rd_ptr];

   // A full buffer still accepts a push when the head leaves in the same cycle
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// +-----------------------------------------------------------------------------+
// | vram_arbiter : single-port VRAM arbiter, buffered CPU writes vs GPU fetch   |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_W     = VRAM_ADDR_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_WAIT   = 8
) (
   input  wire logic     clk,
   input  wire logic     rst,
   vram_arbiter_if.slave bus
);
   localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam int ENTRY_W = ADDR_W + 8;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_wdata;
   logic              r_rvalid;
   logic              r_overflow;

   logic [ENTRY_W-1:0] w_head;
   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_wait_max;
   logic               w_sel_write;
   logic               w_sel_read;

   vram_write_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_sel_write),
      .din   ({bus.address, bus.data}),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // During active display the GPU owns the port until the CPU has starved MAX_WAIT cycles
   assign w_wait_max  = (r_wait_cnt == WAIT_W'(MAX_WAIT));
   assign w_sel_write = !w_empty && (!bus.visible || w_wait_max);
   assign w_sel_read  = !w_sel_write && bus.gpu_req;
   assign w_push      = bus.cs && (!w_full || w_sel_write);

   always_comb begin
      w_next_state = ST_IDLE;
      if (w_sel_write)     w_next_state = ST_WRITE;
      else if (w_sel_read) w_next_state = ST_READ;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_wait_cnt  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rvalid    <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_rvalid <= (r_state == ST_READ);

         if (w_sel_write) begin
            r_mem_addr  <= w_head[ENTRY_W-1:8];
            r_mem_wdata <= w_head[7:0];
         end else if (w_sel_read) begin
            r_mem_addr  <= bus.gpu_addr;
         end

         if (w_empty || w_sel_write) r_wait_cnt <= '0;
         else if (!w_wait_max)       r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

         if (bus.cs && w_full && !w_sel_write) r_overflow <= 1'b1;
      end
   end

   assign bus.gpu_gnt    = w_sel_read && !rst;
   assign bus.mem_we     = (r_state == ST_WRITE);
   assign bus.mem_re     = (r_state == ST_READ);
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.gpu_rvalid = r_rvalid;
   assign bus.gpu_rdata  = bus.mem_rdata;
   assign bus.cpu_full   = (w_count == CNT_W'(FIFO_DEPTH));
   assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_vram_arbiter : directed self-checking bench for vram_arbiter             |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_vram_arbiter;
   import vram_arbiter_pkg::*;

   localparam int AW = VRAM_ADDR_WIDTH;

   logic clk;
   logic rst;
   int   nvec;
   int   nerr;

   logic [31:0] wr_log [$];
   int          n_we;
   int          n_rv;
   int          base;
   int          base_we;
   int          base_rv;

   vram_arbiter_if #(.ADDR_W(AW)) bus ();

   vram_arbiter #(
      .ADDR_W     (AW),
      .FIFO_DEPTH (4),
      .MAX_WAIT   (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // VRAM model: one-cycle read latency, only 0x100 holds non-zero data
   always @(posedge clk) begin
      if (bus.mem_re) bus.mem_rdata <= (bus.mem_addr == AW'(12'h100)) ? 8'h3C : 8'h00;
      if (bus.mem_we) begin
         wr_log.push_back(32'({bus.mem_addr, bus.mem_wdata}));
         n_we++;
      end
      if (bus.gpu_rvalid) n_rv++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst) chk("we_re_exclusive", 32'(bus.mem_we & bus.mem_re), 0);
   endtask

   task automatic chk_log(input string tag, input int idx, input int a, input int d);
      logic [31:0] obs;
      obs = (base + idx < wr_log.size()) ? wr_log[base + idx] : 32'hDEAD_BEEF;
      chk(tag, obs, (a << 8) | d);
   endtask

   task automatic cpu_write(input logic en, input int a, input int d);
      bus.cs      = en;
      bus.address = AW'(a);
      bus.data    = 8'(d);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      n_we = 0;
      n_rv = 0;
      rst  = 1'b1;
      cpu_write(1'b0, 0, 0);
      bus.visible  = 1'b0;
      bus.gpu_req  = 1'b1;
      bus.gpu_addr = '0;

      // Reset: everything quiet even with a GPU request pending
      tick();
      tick();
      chk("rst_gnt",      32'(bus.gpu_gnt),    0);
      chk("rst_we",       32'(bus.mem_we),     0);
      chk("rst_re",       32'(bus.mem_re),     0);
      chk("rst_addr",     32'(bus.mem_addr),   0);
      chk("rst_wdata",    32'(bus.mem_wdata),  0);
      chk("rst_rvalid",   32'(bus.gpu_rvalid), 0);
      chk("rst_full",     32'(bus.cpu_full),   0);
      chk("rst_overflow", 32'(bus.overflow),   0);
      bus.gpu_req = 1'b0;
      rst = 1'b0;
      tick();

      // Scenario 1: blanking write lands two cycles after cs
      base = wr_log.size();
      cpu_write(1'b1, 'h010, 'hA5);
      tick();
      cpu_write(1'b0, 0, 0);
      chk("s1_no_bypass", 32'(bus.mem_we), 0);
      tick();
      chk("s1_we",    32'(bus.mem_we),    1);
      chk("s1_addr",  32'(bus.mem_addr),  'h010);
      chk("s1_wdata", 32'(bus.mem_wdata), 'hA5);
      tick();
      chk("s1_we_once", 32'(bus.mem_we), 0);
      chk("s1_count", 32'(wr_log.size() - base), 1);

      // Scenario 4: read latency gnt N, mem_re N+1, rvalid N+2
      bus.visible  = 1'b1;
      bus.gpu_req  = 1'b1;
      bus.gpu_addr = AW'(12'h100);
      #2;
      chk("s4_gnt", 32'(bus.gpu_gnt), 1);
      tick();
      bus.gpu_req = 1'b0;
      chk("s4_re",     32'(bus.mem_re),     1);
      chk("s4_we",     32'(bus.mem_we),     0);
      chk("s4_addr",   32'(bus.mem_addr),   'h100);
      chk("s4_rv_early", 32'(bus.gpu_rvalid), 0);
      tick();
      chk("s4_rvalid", 32'(bus.gpu_rvalid), 1);
      chk("s4_rdata",  32'(bus.gpu_rdata),  'h3C);
      chk("s4_re_off", 32'(bus.mem_re),     0);
      tick();
      chk("s4_rvalid_off", 32'(bus.gpu_rvalid), 0);

      // Scenario 2: GPU held during display, cs at cycles 0/4/8; stall at 9/18/27
      base = wr_log.size();
      bus.gpu_req  = 1'b1;
      bus.gpu_addr = AW'(12'h020);
      for (int c = 0; c < 32; c++) begin
         cpu_write(c == 0 || c == 4 || c == 8, 'h40 + c, 'h80 + c);
         #2;
         chk("s2_gnt", 32'(bus.gpu_gnt), (c == 9 || c == 18 || c == 27) ? 0 : 1);
         chk("s2_we",  32'(bus.mem_we),  (c == 10 || c == 19 || c == 28) ? 1 : 0);
         tick();
      end
      cpu_write(1'b0, 0, 0);
      bus.gpu_req = 1'b0;
      chk("s2_count", 32'(wr_log.size() - base), 3);
      chk_log("s2_w0", 0, 'h40, 'h80);
      chk_log("s2_w1", 1, 'h44, 'h84);
      chk_log("s2_w2", 2, 'h48, 'h88);
      tick();

      // Scenario 3: five back-to-back writes during display, fifth dropped
      base = wr_log.size();
      for (int c = 0; c < 5; c++) begin
         cpu_write(1'b1, 'h30 + c, 'h11 + c);
         #2;
         if (c == 3) chk("s3_not_full", 32'(bus.cpu_full), 0);
         if (c == 4) begin
            chk("s3_full",     32'(bus.cpu_full), 1);
            chk("s3_ovf_late", 32'(bus.overflow), 0);
         end
         tick();
      end
      cpu_write(1'b0, 0, 0);
      chk("s3_overflow", 32'(bus.overflow), 1);
      for (int k = 0; k < 60 && (wr_log.size() - base) < 4; k++) tick();
      repeat (12) tick();
      chk("s3_count", 32'(wr_log.size() - base), 4);
      for (int i = 0; i < 4; i++) chk_log("s3_order", i, 'h30 + i, 'h11 + i);
      chk("s3_ovf_sticky", 32'(bus.overflow), 1);
      chk("s3_drained",    32'(bus.cpu_full), 0);

      // Scenario 5: reset with three writes buffered and a read in flight
      for (int c = 0; c < 3; c++) begin
         cpu_write(1'b1, 'h60 + c, 'hE0 + c);
         tick();
      end
      cpu_write(1'b0, 0, 0);
      bus.gpu_req  = 1'b1;
      bus.gpu_addr = AW'(12'h100);
      tick();
      bus.gpu_req = 1'b0;
      chk("s5_read_inflight", 32'(bus.mem_re), 1);
      rst = 1'b1;
      #1;
      base_we = n_we;
      base_rv = n_rv;
      chk("s5_we",       32'(bus.mem_we),     0);
      chk("s5_re",       32'(bus.mem_re),     0);
      chk("s5_addr",     32'(bus.mem_addr),   0);
      chk("s5_wdata",    32'(bus.mem_wdata),  0);
      chk("s5_rvalid",   32'(bus.gpu_rvalid), 0);
      chk("s5_gnt",      32'(bus.gpu_gnt),    0);
      chk("s5_full",     32'(bus.cpu_full),   0);
      chk("s5_overflow", 32'(bus.overflow),   0);
      tick();
      tick();
      rst = 1'b0;
      bus.visible = 1'b0;
      repeat (20) tick();
      chk("s5_no_write",  32'(n_we - base_we), 0);
      chk("s5_no_rvalid", 32'(n_rv - base_rv), 0);

      // Scenario 6: push into a full buffer in the same cycle the head pops
      base = wr_log.size();
      bus.visible = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c < 4)       cpu_write(1'b1, 'h50 + c, 'hD0 + c);
         else if (c == 9) cpu_write(1'b1, 'h55, 'hD9);
         else             cpu_write(1'b0, 0, 0);
         #2;
         if (c == 9) chk("s6_full_at_pop", 32'(bus.cpu_full), 1);
         tick();
      end
      cpu_write(1'b0, 0, 0);
      chk("s6_overflow",  32'(bus.overflow), 0);
      chk("s6_refilled",  32'(bus.cpu_full), 1);
      bus.visible = 1'b0;
      for (int k = 0; k < 40 && (wr_log.size() - base) < 5; k++) tick();
      repeat (4) tick();
      chk("s6_count", 32'(wr_log.size() - base), 5);
      for (int i = 0; i < 4; i++) chk_log("s6_order", i, 'h50 + i, 'hD0 + i);
      chk_log("s6_last", 4, 'h55, 'hD9);
      chk("s6_ovf_final", 32'(bus.overflow), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
